dm_arbiter: RTL and testbench

//   Sequences and shares the single data-memory (DM) instance between two requesters:

---
 rtl/dm_arbiter_if.sv | 14 +
 rtl/dm_arbiter.sv | 143 ++++++++++++++
 tb/tb_dm_arbiter.sv | 243 ++++++++++++++++++++++++
 3 files changed

// File: rtl/dm_arbiter_if.sv
// One requester's req/ack channel to the DM arbiter; master = requester, slave = arbiter.
// The request fields are held stable from req until ack; err/rdata are valid with ack.
interface dm_arbiter_if;
    logic        req;
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        ack;
    logic        err;
    logic [31:0] rdata;

    modport master (output req, we, addr, wdata, input ack, err, rdata);
    modport slave  (input req, we, addr, wdata, output ack, err, rdata);
endinterface

// File: rtl/dm_arbiter.sv
// Shares one DM between ports A/B: IDLE->ACCESS(LATENCY)->RESP, ack LATENCY+1 cycles after grant, 1 if misaligned;
// losers stall on req until IDLE. DM_ARB_ROUND_ROBIN_EN selects round-robin ties, else A has fixed priority.
module dm_arbiter #(
    parameter int LATENCY = 1,
    parameter int CNT_W   = 4
) (
    input  logic        clk,
    input  logic        reset,
    dm_arbiter_if.slave a_if,
    dm_arbiter_if.slave b_if,
    output logic [31:0] dm_addr_o,
    output logic [31:0] dm_wdata_o,
    output logic        dm_re_o,
    output logic        dm_we_o,
    input  logic [31:0] dm_rdata_i,
    output logic        busy_o
);
    typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_e;
    typedef enum logic {OWN_A, OWN_B} owner_e;

    localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(LATENCY - 1);

    state_e            state_q, state_d;
    owner_e            owner_q, owner_d;
    owner_e            last_owner_q, last_owner_d;
    logic              we_q, we_d;
    logic [31:2]       addr_q, addr_d;
    logic [31:0]       wdata_q, wdata_d;
    logic              err_q, err_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [31:0]       a_rdata_q, a_rdata_d;
    logic [31:0]       b_rdata_q, b_rdata_d;

    logic              grant_b;
    logic              sel_we;
    logic [31:0]       sel_addr;
    logic [31:0]       sel_wdata;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= IDLE;
            owner_q      <= OWN_A;
            last_owner_q <= OWN_B;
            we_q         <= 1'b0;
            addr_q       <= '0;
            wdata_q      <= '0;
            err_q        <= 1'b0;
            cnt_q        <= '0;
            a_rdata_q    <= '0;
            b_rdata_q    <= '0;
        end else begin
            state_q      <= state_d;
            owner_q      <= owner_d;
            last_owner_q <= last_owner_d;
            we_q         <= we_d;
            addr_q       <= addr_d;
            wdata_q      <= wdata_d;
            err_q        <= err_d;
            cnt_q        <= cnt_d;
            a_rdata_q    <= a_rdata_d;
            b_rdata_q    <= b_rdata_d;
        end
    end

    always_comb begin
`ifdef DM_ARB_ROUND_ROBIN_EN
        grant_b = b_if.req && (!a_if.req || last_owner_q == OWN_A);
`else
        grant_b = b_if.req && !a_if.req;
`endif
        sel_we    = grant_b ? b_if.we    : a_if.we;
        sel_addr  = grant_b ? b_if.addr  : a_if.addr;
        sel_wdata = grant_b ? b_if.wdata : a_if.wdata;
    end

    always_comb begin
        state_d      = state_q;
        owner_d      = owner_q;
        last_owner_d = last_owner_q;
        we_d         = we_q;
        addr_d       = addr_q;
        wdata_d      = wdata_q;
        err_d        = err_q;
        cnt_d        = cnt_q;
        a_rdata_d    = a_rdata_q;
        b_rdata_d    = b_rdata_q;
        dm_addr_o    = '0;
        dm_wdata_o   = '0;
        dm_re_o      = 1'b0;
        dm_we_o      = 1'b0;

        case (state_q)
            IDLE: begin
                if (a_if.req || b_if.req) begin
                    owner_d      = grant_b ? OWN_B : OWN_A;
                    last_owner_d = owner_d;
                    we_d         = sel_we;
                    addr_d       = sel_addr[31:2];
                    wdata_d      = sel_wdata;
                    // Misaligned requests skip DM entirely and answer with err.
                    if (sel_addr[1:0] == 2'b00) begin
                        state_d = ACCESS;
                        cnt_d   = CNT_INIT;
                        err_d   = 1'b0;
                    end else begin
                        state_d = RESP;
                        err_d   = 1'b1;
                    end
                end
            end
            ACCESS: begin
                dm_addr_o  = {addr_q, 2'b00};
                dm_wdata_o = wdata_q;
                dm_re_o    = !we_q;
                // cnt still at its load value marks the first cycle: exactly one write per store.
                dm_we_o    = we_q && (cnt_q == CNT_INIT);
                if (cnt_q == '0) begin
                    state_d = RESP;
                    if (!we_q) begin
                        if (owner_q == OWN_A) a_rdata_d = dm_rdata_i;
                        else                  b_rdata_d = dm_rdata_i;
                    end
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            RESP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign a_if.ack   = (state_q == RESP) && (owner_q == OWN_A);
    assign b_if.ack   = (state_q == RESP) && (owner_q == OWN_B);
    assign a_if.err   = a_if.ack && err_q;
    assign b_if.err   = b_if.ack && err_q;
    assign a_if.rdata = a_rdata_q;
    assign b_if.rdata = b_rdata_q;
    assign busy_o     = (state_q != IDLE);
endmodule

// File: tb/tb_dm_arbiter.sv
// Directed bench: dut1 (LATENCY=1) for the single-cycle load, dut3 (LATENCY=3) for everything else.
module tb_dm_arbiter;
    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    dm_arbiter_if a1 ();
    dm_arbiter_if b1 ();
    dm_arbiter_if a3 ();
    dm_arbiter_if b3 ();

    logic [31:0] dm1_addr, dm1_wdata, dm1_rdata;
    logic [31:0] dm3_addr, dm3_wdata, dm3_rdata;
    logic        dm1_re, dm1_we, dm3_re, dm3_we, busy1, busy3;

    dm_arbiter #(.LATENCY(1), .CNT_W(4)) dut1 (
        .clk(clk), .reset(reset), .a_if(a1), .b_if(b1),
        .dm_addr_o(dm1_addr), .dm_wdata_o(dm1_wdata), .dm_re_o(dm1_re),
        .dm_we_o(dm1_we), .dm_rdata_i(dm1_rdata), .busy_o(busy1)
    );

    dm_arbiter #(.LATENCY(3), .CNT_W(4)) dut3 (
        .clk(clk), .reset(reset), .a_if(a3), .b_if(b3),
        .dm_addr_o(dm3_addr), .dm_wdata_o(dm3_wdata), .dm_re_o(dm3_re),
        .dm_we_o(dm3_we), .dm_rdata_i(dm3_rdata), .busy_o(busy3)
    );

    // dut1 memory: only word 0x10 holds data.
    assign dm1_rdata = (dm1_addr == 32'h0000_0010) ? 32'hDEAD_BEEF : 32'h0;

    // dut3 memory: written words read back, unwritten words read 0xCAFE_00<index>.
    logic [31:0] mem3 [0:63];
    bit   [63:0] wr3;
    always @(posedge clk) begin
        if (dm3_we) begin
            mem3[dm3_addr[7:2]] <= dm3_wdata;
            wr3[dm3_addr[7:2]]  <= 1'b1;
        end
    end
    assign dm3_rdata = wr3[dm3_addr[7:2]] ? mem3[dm3_addr[7:2]]
                                          : (32'hCAFE_0000 | {26'd0, dm3_addr[7:2]});

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic chk1(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    // Cycles from now until the chosen dut3 port acks, capped at 20.
    task automatic wait_ack(input bit on_b, output int n);
        n = 0;
        do begin
            tick();
            n++;
        end while (!(on_b ? b3.ack : a3.ack) && n < 20);
    endtask

    initial begin
        int n;
        int bcount;
        int bothhi;
        logic got_b;
        logic exp_b;

        a1.req = 0; a1.we = 0; a1.addr = 0; a1.wdata = 0;
        b1.req = 0; b1.we = 0; b1.addr = 0; b1.wdata = 0;
        a3.req = 0; a3.we = 0; a3.addr = 0; a3.wdata = 0;
        b3.req = 0; b3.we = 0; b3.addr = 0; b3.wdata = 0;
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;

        // Reset state
        chk1 ("rst_busy1",  busy1, 1'b0);
        chk1 ("rst_busy3",  busy3, 1'b0);
        chk1 ("rst_a_ack",  a3.ack, 1'b0);
        chk1 ("rst_b_ack",  b3.ack, 1'b0);
        chk1 ("rst_a_err",  a3.err, 1'b0);
        chk32("rst_a_rdata", a3.rdata, 32'h0);
        chk32("rst_b_rdata", b3.rdata, 32'h0);
        chk1 ("rst_dm_re",  dm3_re, 1'b0);
        chk1 ("rst_dm_we",  dm3_we, 1'b0);
        chk32("rst_dm_addr", dm3_addr, 32'h0);

        // LATENCY=1 load of 0x10
        a1.req = 1; a1.we = 0; a1.addr = 32'h0000_0010;
        tick();
        chk1 ("t1_c1_re",   dm1_re, 1'b1);
        chk1 ("t1_c1_we",   dm1_we, 1'b0);
        chk32("t1_c1_addr", dm1_addr, 32'h0000_0010);
        chk1 ("t1_c1_ack",  a1.ack, 1'b0);
        tick();
        chk1 ("t1_c2_ack",   a1.ack, 1'b1);
        chk1 ("t1_c2_err",   a1.err, 1'b0);
        chk32("t1_c2_rdata", a1.rdata, 32'hDEAD_BEEF);
        chk1 ("t1_c2_re",    dm1_re, 1'b0);
        chk32("t1_c2_wdata", dm1_wdata, 32'h0);
        a1.req = 0;
        tick();
        chk1 ("t1_c3_ack",  a1.ack, 1'b0);
        chk1 ("t1_c3_busy", busy1, 1'b0);

        // LATENCY=3 store from B
        b3.req = 1; b3.we = 1; b3.addr = 32'h0000_0020; b3.wdata = 32'h1234_5678;
        tick();
        chk1 ("t2_c1_we",    dm3_we, 1'b1);
        chk1 ("t2_c1_re",    dm3_re, 1'b0);
        chk32("t2_c1_addr",  dm3_addr, 32'h0000_0020);
        chk32("t2_c1_wdata", dm3_wdata, 32'h1234_5678);
        tick();
        chk1 ("t2_c2_we",   dm3_we, 1'b0);
        chk1 ("t2_c2_re",   dm3_re, 1'b0);
        chk1 ("t2_c2_busy", busy3, 1'b1);
        tick();
        chk1 ("t2_c3_we",  dm3_we, 1'b0);
        chk1 ("t2_c3_ack", b3.ack, 1'b0);
        tick();
        chk1 ("t2_c4_ack",   b3.ack, 1'b1);
        chk1 ("t2_c4_err",   b3.err, 1'b0);
        chk32("t2_c4_rdata", b3.rdata, 32'h0);
        chk1 ("t2_c4_a_ack", a3.ack, 1'b0);
        b3.req = 0; b3.we = 0;
        tick();
        a3.req = 1; a3.we = 0; a3.addr = 32'h0000_0020;
        wait_ack(1'b0, n);
        chk32("t2_rb_lat",    32'(n), 32'd4);
        chk32("t2_rb_rdata",  a3.rdata, 32'h1234_5678);
        chk32("t2_rb_brdata", b3.rdata, 32'h0);
        a3.req = 0;
        tick();

        // Misaligned A load
        a3.req = 1; a3.we = 0; a3.addr = 32'h0000_0013;
        tick();
        chk1 ("t3_ack",   a3.ack, 1'b1);
        chk1 ("t3_err",   a3.err, 1'b1);
        chk32("t3_rdata", a3.rdata, 32'h1234_5678);
        chk1 ("t3_re",    dm3_re, 1'b0);
        chk1 ("t3_we",    dm3_we, 1'b0);
        a3.req = 0;
        tick();
        chk1 ("t3_after_ack", a3.ack, 1'b0);
        chk1 ("t3_after_err", a3.err, 1'b0);
        chk1 ("t3_after_busy", busy3, 1'b0);

        // Both ports requesting continuously, from reset (last_owner=B)
        reset = 1'b1;
        tick();
        reset = 1'b0;
        a3.req = 1; a3.we = 0; a3.addr = 32'h0000_0030;
        b3.req = 1; b3.we = 0; b3.addr = 32'h0000_0034;
        bcount = 0;
        bothhi = 0;
        for (int k = 0; k < 4; k++) begin
            n = 0;
            do begin
                tick();
                n++;
                if (a3.ack && b3.ack) bothhi++;
            end while (!(a3.ack || b3.ack) && n < 20);
            got_b = b3.ack;
            if (got_b) bcount++;
`ifdef DM_ARB_ROUND_ROBIN_EN
            exp_b = (k % 2) == 1;
`else
            exp_b = 1'b0;
`endif
            chk1 ($sformatf("t4_grant_is_b_%0d", k), got_b, exp_b);
            chk32($sformatf("t4_lat_%0d", k), 32'(n), (k == 0) ? 32'd4 : 32'd5);
        end
        a3.req = 0; b3.req = 0;
        tick();
        tick();
        chk32("t4_both_ack", 32'(bothhi), 32'd0);
`ifdef DM_ARB_ROUND_ROBIN_EN
        chk32("t4_b_acks",   32'(bcount), 32'd2);
        chk32("t4_b_rdata",  b3.rdata, 32'hCAFE_000D);
`else
        chk32("t4_b_acks",   32'(bcount), 32'd0);
        chk32("t4_b_rdata",  b3.rdata, 32'h0);
`endif
        chk32("t4_a_rdata",  a3.rdata, 32'hCAFE_000C);

        // Reset during the second ACCESS cycle of an A load
        a3.req = 1; a3.we = 0; a3.addr = 32'h0000_0010;
        tick();
        tick();
        chk1 ("t5_pre_busy", busy3, 1'b1);
        chk1 ("t5_pre_re",   dm3_re, 1'b1);
        reset = 1'b1;
        a3.req = 0;
        tick();
        chk1 ("t5_busy",    busy3, 1'b0);
        chk1 ("t5_ack",     a3.ack, 1'b0);
        chk1 ("t5_re",      dm3_re, 1'b0);
        chk32("t5_addr",    dm3_addr, 32'h0);
        chk32("t5_a_rdata", a3.rdata, 32'h0);
        chk32("t5_b_rdata", b3.rdata, 32'h0);
        reset = 1'b0;
        tick();

        // A requests while B owns the DM
        b3.req = 1; b3.we = 0; b3.addr = 32'h0000_0020;
        tick();
        a3.req = 1; a3.we = 0; a3.addr = 32'h0000_0010;
        wait_ack(1'b1, n);
        chk32("t6_b_lat",   32'(n), 32'd3);
        chk1 ("t6_a_wait",  a3.ack, 1'b0);
        chk32("t6_b_rdata", b3.rdata, 32'h1234_5678);
        chk32("t6_a_hold",  a3.rdata, 32'h0);
        b3.req = 0;
        tick();
        chk1 ("t6_idle_busy", busy3, 1'b0);
        wait_ack(1'b0, n);
        chk32("t6_a_lat",    32'(n), 32'd4);
        chk32("t6_a_rdata",  a3.rdata, 32'hCAFE_0004);
        chk32("t6_b_keep",   b3.rdata, 32'h1234_5678);
        a3.req = 0;
        tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
